// File: rtl/t_intersection_pkg.sv
// t_intersection_pkg: light codes, phase/state types and the legal phase table for the T-intersection monitor
package t_intersection_pkg;
  localparam int NUM_PHASES = 6;
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam int DEF_DWELL_P0 = 8;
  localparam int DEF_DWELL_P1 = 3;
  localparam int DEF_DWELL_P2 = 6;
  localparam int DEF_DWELL_P3 = 3;
  localparam int DEF_DWELL_P4 = 4;
  localparam int DEF_DWELL_P5 = 3;
  typedef enum logic [2:0] {P0, P1, P2, P3, P4, P5} phase_e;
  typedef enum logic [1:0] {ACQUIRE, TRACK, FAULT} mon_state_e;
  typedef struct packed {
    logic ill;
    logic seq;
    logic dwell;
  } err_t;
  // Entries are packed {LS, RB, LR, BR}
  localparam logic [11:0] PHASE_TABLE [NUM_PHASES] = '{
    {LIGHT_GRN, LIGHT_GRN, LIGHT_RED, LIGHT_RED},
    {LIGHT_GRN, LIGHT_YEL, LIGHT_RED, LIGHT_RED},
    {LIGHT_GRN, LIGHT_RED, LIGHT_GRN, LIGHT_RED},
    {LIGHT_YEL, LIGHT_RED, LIGHT_YEL, LIGHT_RED},
    {LIGHT_RED, LIGHT_RED, LIGHT_RED, LIGHT_GRN},
    {LIGHT_RED, LIGHT_RED, LIGHT_RED, LIGHT_YEL}
  };
  function automatic phase_e next_phase(phase_e p);
    return p == P5 ? P0 : phase_e'(p + 3'd1);
  endfunction
endpackage

// File: rtl/t_intersection_light_monitor_if.sv
// t_intersection_light_monitor_if: light buses, clear and status outputs of the light monitor
interface t_intersection_light_monitor_if #(parameter int CYC_W = 16);
  logic [2:0] light_LS;
  logic [2:0] light_BR;
  logic [2:0] light_LR;
  logic [2:0] light_RB;
  logic clr;
  logic [2:0] phase;
  logic phase_valid;
  logic locked;
  logic err_illegal;
  logic err_sequence;
  logic err_dwell;
  logic [CYC_W-1:0] cycle_count;
  modport master (
    output light_LS, light_BR, light_LR, light_RB, clr,
    input phase, phase_valid, locked, err_illegal, err_sequence, err_dwell, cycle_count
  );
  modport slave (
    input light_LS, light_BR, light_LR, light_RB, clr,
    output phase, phase_valid, locked, err_illegal, err_sequence, err_dwell, cycle_count
  );
endinterface

// File: rtl/t_intersection_phase_decoder.sv
// t_intersection_phase_decoder: maps a 12-bit {LS,RB,LR,BR} light word to its phase index and a valid flag
module t_intersection_phase_decoder
  import t_intersection_pkg::*;
(
  input  logic [11:0] lights,
  output phase_e      phase,
  output logic        valid
);
  always_comb begin
    phase = P0;
    valid = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (lights == PHASE_TABLE[i]) begin
        phase = phase_e'(i[2:0]);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/t_intersection_light_monitor.sv
// t_intersection_light_monitor: passive checker of phase legality, order and dwell on the intersection lights.
// Dwell checking is built only when T_INTERSECTION_MON_DWELL_CHECK_EN is defined; otherwise err_dwell is 0.
module t_intersection_light_monitor
  import t_intersection_pkg::*;
#(
  parameter int DWELL_P0 = DEF_DWELL_P0,
  parameter int DWELL_P1 = DEF_DWELL_P1,
  parameter int DWELL_P2 = DEF_DWELL_P2,
  parameter int DWELL_P3 = DEF_DWELL_P3,
  parameter int DWELL_P4 = DEF_DWELL_P4,
  parameter int DWELL_P5 = DEF_DWELL_P5,
  parameter int CNT_W    = 4,
  parameter int CYC_W    = 16
) (
  input logic clk,
  input logic rst,
  t_intersection_light_monitor_if.slave bus
);
  mon_state_e state_q, state_d;
  logic [11:0] sample_q, sample_d;
  logic seen_q, seen_d, have_last_q, have_last_d, phase_valid_q, phase_valid_d;
  phase_e phase_q, phase_d, dec_phase;
  logic dec_valid, change, bad_dwell;
  err_t err_q, err_d, new_err;
  logic [CYC_W-1:0] cycle_q, cycle_d;

  t_intersection_phase_decoder u_dec (.lights(sample_q), .phase(dec_phase), .valid(dec_valid));

  // A valid sample after an illegal one counts as a change even if it repeats the last phase
  always_comb begin
    sample_d = {bus.light_LS, bus.light_RB, bus.light_LR, bus.light_BR};
    seen_d = 1'b1;
    change = dec_valid && have_last_q && (dec_phase != phase_q || !phase_valid_q);
    phase_d = dec_valid ? dec_phase : phase_q;
    phase_valid_d = dec_valid;
    have_last_d = have_last_q | dec_valid;
  end

`ifdef T_INTERSECTION_MON_DWELL_CHECK_EN
  localparam logic [CNT_W-1:0] DWELL [NUM_PHASES] = '{
    CNT_W'(DWELL_P0), CNT_W'(DWELL_P1), CNT_W'(DWELL_P2),
    CNT_W'(DWELL_P3), CNT_W'(DWELL_P4), CNT_W'(DWELL_P5)
  };
  logic [CNT_W-1:0] dwell_q, dwell_d;
  always_comb begin
    bad_dwell = state_q == TRACK && dec_valid &&
                (change ? dwell_q < DWELL[phase_q] : dwell_q == DWELL[phase_q]);
  end
  always_comb begin
    dwell_d = state_d != TRACK ? '0 : change ? CNT_W'(1) : dwell_q == '1 ? dwell_q : dwell_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    dwell_q <= rst ? '0 : dwell_d;
  end
`else
  localparam int unused_dwell = DWELL_P0 + DWELL_P1 + DWELL_P2 + DWELL_P3 + DWELL_P4 + DWELL_P5 + CNT_W;
  assign bad_dwell = 1'b0;
`endif

  // A newly detected error outranks clr in the same cycle
  always_comb begin
    new_err = '{ill: seen_q && !dec_valid,
                seq: state_q == TRACK && change && dec_phase != next_phase(phase_q),
                dwell: bad_dwell};
    err_d = bus.clr ? new_err : err_t'(err_q | new_err);
    state_d = |new_err ? FAULT : bus.clr ? ACQUIRE : (state_q == ACQUIRE && change) ? TRACK : state_q;
    cycle_d = cycle_q + CYC_W'(state_q == TRACK && change && phase_q == P5 && dec_phase == P0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACQUIRE;
      sample_q <= '0;
      seen_q <= 1'b0;
      have_last_q <= 1'b0;
      phase_q <= P0;
      phase_valid_q <= 1'b0;
      err_q <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      sample_q <= sample_d;
      seen_q <= seen_d;
      have_last_q <= have_last_d;
      phase_q <= phase_d;
      phase_valid_q <= phase_valid_d;
      err_q <= err_d;
      cycle_q <= cycle_d;
    end
  end

  assign bus.phase = phase_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.locked = state_q == TRACK;
  assign bus.err_illegal = err_q.ill;
  assign bus.err_sequence = err_q.seq;
  assign bus.err_dwell = err_q.dwell;
  assign bus.cycle_count = cycle_q;
endmodule

// File: tb/tb_t_intersection_light_monitor.sv
// tb_t_intersection_light_monitor: directed and random stimulus checked against a phase-rule model of the monitor
module tb_t_intersection_light_monitor;
`ifdef T_INTERSECTION_MON_DWELL_CHECK_EN
  localparam bit DWELL_EN = 1'b1;
`else
  localparam bit DWELL_EN = 1'b0;
`endif
  localparam int DW [6] = '{8, 3, 6, 3, 4, 3};
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
  localparam logic [11:0] TBL [6] = '{{G, G, R, R}, {G, Y, R, R}, {G, R, G, R},
                                      {Y, R, Y, R}, {R, R, R, G}, {R, R, R, Y}};

  // smp: phase of the registered sample, -1 illegal, -2 nothing captured since reset
  typedef struct {
    int smp;
    int ph;
    bit pv, lk, flt, have, ei, es, ed;
    int run;
    int cyc;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cur_ph = -2;
  int checks = 0;
  int passed = 0;
  int plan[$];
  model_t m = '{smp: -2, default: 0};

  t_intersection_light_monitor_if bus ();
  t_intersection_light_monitor dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic model_t step(model_t s, int s_new, bit c, bit r);
    model_t n;
    bit valid, chg, ill, seq, dw;
    n = s;
    if (r) begin
      n = '{smp: -2, default: 0};
      return n;
    end
    valid = s.smp >= 0;
    ill = s.smp == -1;
    chg = valid && s.have && (s.smp != s.ph || !s.pv);
    seq = s.lk && chg && s.smp != (s.ph + 1) % 6;
    dw = DWELL_EN && s.lk && valid && (chg ? s.run < DW[s.ph] : s.run >= DW[s.ph]);
    if (c) begin
      n.ei = 1'b0;
      n.es = 1'b0;
      n.ed = 1'b0;
    end
    n.ei |= ill;
    n.es |= seq;
    n.ed |= dw;
    if (s.lk && chg && s.ph == 5 && s.smp == 0) n.cyc = (s.cyc + 1) % 65536;
    if (ill || seq || dw) begin
      n.lk = 1'b0;
      n.flt = 1'b1;
    end else if (c) begin
      n.lk = 1'b0;
      n.flt = 1'b0;
    end else if (!s.lk && !s.flt && chg) n.lk = 1'b1;
    n.run = !n.lk ? 0 : chg ? 1 : s.run + 1;
    if (valid) begin
      n.ph = s.smp;
      n.have = 1'b1;
    end
    n.pv = valid;
    n.smp = s_new;
    return n;
  endfunction

  always @(posedge clk) m <= step(m, cur_ph, bus.clr, rst);

  function automatic logic [23:0] dut_vec();
    return {bus.phase, bus.phase_valid, bus.locked, bus.err_illegal, bus.err_sequence, bus.err_dwell, bus.cycle_count};
  endfunction

  function automatic logic [23:0] exp_vec();
    return {3'(m.ph), m.pv, m.lk, m.ei, m.es, m.ed, 16'(m.cyc)};
  endfunction

  function automatic logic [11:0] rand_bad();
    logic [11:0] v;
    v = 12'($urandom);
    foreach (TBL[i]) if (v == TBL[i]) v = '0;
    return v;
  endfunction

  function automatic void add(int p, int n);
    repeat (n) plan.push_back(p);
  endfunction

  function automatic void add_cycle();
    for (int i = 0; i < 6; i++) add(i, DW[i]);
  endfunction

  task automatic tick(input int p, input bit c = 1'b0, input logic [11:0] bad = 12'h000);
    logic [11:0] code;
    code = bad;
    if (p >= 0) code = TBL[p];
    {bus.light_LS, bus.light_RB, bus.light_LR, bus.light_BR} = code;
    bus.clr = c;
    cur_ph = p;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(-2);
    tick(-2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    tick(2);
    checks++;
    if (dut_vec() !== 24'h0) $display("FAIL reset_values got=%h want=%h", dut_vec(), 24'h0);
    else passed++;
    rst = 1'b0;
    tick(0);
    checks++;
    if (dut_vec() !== 24'h0) $display("FAIL reset_sample_not_flagged got=%h want=%h", dut_vec(), 24'h0);
    else passed++;
  endtask

  task automatic test_legal_seq();
    do_reset();
    plan.delete();
    repeat (3) add_cycle();
    add(0, 1);
    foreach (plan[i]) begin
      tick(plan[i]);
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL legal_seq t=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      else passed++;
    end
    checks++;
    if ({bus.locked, bus.err_illegal, bus.err_sequence, bus.err_dwell, bus.phase} !== 7'b1000_101)
      $display("FAIL legal_status got=%b want=%b",
               {bus.locked, bus.err_illegal, bus.err_sequence, bus.err_dwell, bus.phase}, 7'b1000_101);
    else passed++;
    checks++;
    if (bus.cycle_count !== 16'd2) $display("FAIL legal_cycle_count got=%0d want=2", bus.cycle_count);
    else passed++;
  endtask

  task automatic test_dwell();
    do_reset();
    plan.delete();
    add(0, 8);
    add(1, 3);
    add(2, 20);
    foreach (plan[i]) begin
      tick(plan[i]);
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL dwell_hold t=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      else passed++;
    end
    checks++;
    if ({bus.err_dwell, bus.err_sequence, bus.err_illegal, bus.locked} !== {DWELL_EN, 2'b00, !DWELL_EN})
      $display("FAIL dwell_flags got=%b want=%b",
               {bus.err_dwell, bus.err_sequence, bus.err_illegal, bus.locked}, {DWELL_EN, 2'b00, !DWELL_EN});
    else passed++;
  endtask

  task automatic test_sequence();
    do_reset();
    plan.delete();
    add(0, 8);
    add(1, 3);
    add(3, 3);
    foreach (plan[i]) begin
      tick(plan[i]);
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL sequence t=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      else passed++;
    end
    checks++;
    if ({bus.err_sequence, bus.err_dwell, bus.err_illegal, bus.locked, bus.phase} !== 7'b1000_011)
      $display("FAIL sequence_flags got=%b want=%b",
               {bus.err_sequence, bus.err_dwell, bus.err_illegal, bus.locked, bus.phase}, 7'b1000_011);
    else passed++;
  endtask

  task automatic test_illegal_clr();
    do_reset();
    plan.delete();
    add_cycle();
    add(0, 4);
    foreach (plan[i]) begin
      tick(plan[i]);
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL illegal_pre t=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      else passed++;
    end
    tick(-1, 1'b0, 12'h000);
    tick(0);
    checks++;
    if ({bus.err_illegal, bus.phase, bus.phase_valid, bus.locked} !== 6'b1_000_00)
      $display("FAIL dark_sample got=%b want=%b", {bus.err_illegal, bus.phase, bus.phase_valid, bus.locked}, 6'b1_000_00);
    else passed++;
    tick(0, 1'b1);
    checks++;
    if ({bus.err_illegal, bus.err_sequence, bus.err_dwell, bus.locked} !== 4'b0000)
      $display("FAIL clr_clears got=%b want=0000", {bus.err_illegal, bus.err_sequence, bus.err_dwell, bus.locked});
    else passed++;
    plan.delete();
    add(0, 6);
    add_cycle();
    foreach (plan[i]) begin
      tick(plan[i]);
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL relock t=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      else passed++;
    end
    checks++;
    if ({bus.locked, bus.err_illegal, bus.err_sequence, bus.err_dwell} !== 4'b1000)
      $display("FAIL relock_status got=%b want=1000", {bus.locked, bus.err_illegal, bus.err_sequence, bus.err_dwell});
    else passed++;
    tick(1);
    tick(1);
    checks++;
    if (bus.err_sequence !== 1'b1) $display("FAIL skip_to_p1 got=%b want=1", bus.err_sequence);
    else passed++;
    tick(-1, 1'b0, rand_bad());
    tick(1, 1'b1);
    checks++;
    if ({bus.err_illegal, bus.err_sequence, bus.err_dwell, bus.locked, bus.phase_valid} !== 5'b10000)
      $display("FAIL clr_vs_illegal got=%b want=10000",
               {bus.err_illegal, bus.err_sequence, bus.err_dwell, bus.locked, bus.phase_valid});
    else passed++;
    checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL clr_vs_illegal_model got=%h want=%h", dut_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_random();
    int p;
    int n;
    int r;
    logic [11:0] bad;
    p = 0;
    do_reset();
    for (int seg = 0; seg < 200; seg++) begin
      r = int'($urandom_range(0, 99));
      if (r < 80) p = (p < 0) ? 0 : (p + 1) % 6;
      else if (r < 92) p = int'($urandom_range(0, 5));
      else p = -1;
      if (p < 0) n = int'($urandom_range(1, 2));
      else if ($urandom_range(0, 3) == 0) n = int'($urandom_range(1, DW[p] + 3));
      else n = DW[p];
      bad = rand_bad();
      repeat (n) begin
        tick(p, $urandom_range(0, 39) == 0, bad);
        checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL random seg=%0d got=%h want=%h", seg, dut_vec(), exp_vec());
        else passed++;
      end
    end
  endtask

  initial begin
    bus.clr = 1'b0;
    {bus.light_LS, bus.light_RB, bus.light_LR, bus.light_BR} = 12'h000;
    test_reset();
    test_legal_seq();
    test_dwell();
    test_sequence();
    test_illegal_clr();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
